// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, default widths and peripheral map for the AHB2APB bridge.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        RENABLE,
        WRITE,
        WENABLE,
        WRITEP,
        WENABLEP
    } state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NSEL_DEF   = 3;

    localparam logic [31:0] PERIPH0_BASE = 32'h4000_0000;
    localparam logic [31:0] PERIPH1_BASE = 32'h4000_1000;
    localparam logic [31:0] PERIPH2_BASE = 32'h4000_2000;
    localparam logic [31:0] REGION_TOP   = 32'h4000_FFFF;

    // Only the 4 KB windows up to the last peripheral base carry a real select.
    function automatic logic sel_in_range(input logic [3:0] nib);
        return nib <= PERIPH2_BASE[15:12];
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences APB setup/enable phases for AHB transfers,
// with one pending transfer accepted behind a posted write.
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSEL   = NSEL_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              valid,
    input  logic              HWRITE,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic [NSEL-1:0]   TEMP_SEL,
    output logic [NSEL-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              HREADYout
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_addr_p, w_addr_d;
    logic [NSEL-1:0]   r_sel, r_sel_p, w_sel_d, w_sel_in;
    logic              r_dir, r_dir_p, w_dir_d;
    logic [DATA_W-1:0] r_data, w_data_d;
    logic              w_acc, w_cap, w_cap_p;
    logic [NSEL-1:0]   r_psel, w_psel;
    logic              r_penable, w_penable, r_pwrite, w_pwrite, r_hready, w_hready;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;

    assign w_acc    = valid & r_hready;
    assign w_cap    = w_acc & (r_state != WWAIT);
    assign w_cap_p  = w_acc & (r_state == WWAIT);
    assign w_sel_in = sel_in_range(HADDR[15:12]) ? TEMP_SEL : '0;

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign HREADYout = r_hready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE, RENABLE, WENABLE: w_state_nxt = w_acc ? (HWRITE ? WWAIT : READ) : IDLE;
            WWAIT:                  w_state_nxt = w_acc ? WRITEP : WRITE;
            READ:                   w_state_nxt = RENABLE;
            WRITE:                  w_state_nxt = WENABLE;
            WRITEP:                 w_state_nxt = WENABLEP;
            WENABLEP:               w_state_nxt = r_dir_p ? WRITE : READ;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Next values of the active transfer registers; the setup outputs load from these
    // so a transfer captured on this edge is already on the APB bus next cycle.
    always_comb begin
        w_addr_d = r_addr;
        w_sel_d  = r_sel;
        w_dir_d  = r_dir;
        w_data_d = r_data;
        if (w_cap) begin
            w_addr_d = HADDR;
            w_sel_d  = w_sel_in;
            w_dir_d  = HWRITE;
        end
        if (r_state == WENABLEP) begin
            w_addr_d = r_addr_p;
            w_sel_d  = r_sel_p;
            w_dir_d  = r_dir_p;
        end
        if (r_state == WWAIT || (r_state == WENABLEP && r_dir_p))
            w_data_d = HWDATA;
    end

    always_comb begin
        w_psel    = r_psel;
        w_penable = 1'b0;
        w_pwrite  = r_pwrite;
        w_paddr   = r_paddr;
        w_pwdata  = r_pwdata;
        w_hready  = 1'b1;
        case (w_state_nxt)
            READ: begin
                w_psel   = w_sel_d;
                w_paddr  = w_addr_d;
                w_pwrite = 1'b0;
                w_hready = 1'b0;
            end
            WRITE, WRITEP: begin
                w_psel   = w_sel_d;
                w_paddr  = w_addr_d;
                w_pwdata = w_data_d;
                w_pwrite = 1'b1;
                w_hready = 1'b0;
            end
            RENABLE, WENABLE: w_penable = 1'b1;
            WENABLEP: begin
                w_penable = 1'b1;
                w_hready  = 1'b0;
            end
            default: w_psel = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr    <= '0;
            r_sel     <= '0;
            r_dir     <= 1'b0;
            r_data    <= '0;
            r_addr_p  <= '0;
            r_sel_p   <= '0;
            r_dir_p   <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_hready  <= 1'b1;
        end else begin
            r_addr    <= w_addr_d;
            r_sel     <= w_sel_d;
            r_dir     <= w_dir_d;
            r_data    <= w_data_d;
            if (w_cap_p) begin
                r_addr_p <= HADDR;
                r_sel_p  <= w_sel_in;
                r_dir_p  <= HWRITE;
            end
            r_psel    <= w_psel;
            r_penable <= w_penable;
            r_pwrite  <= w_pwrite;
            r_paddr   <= w_paddr;
            r_pwdata  <= w_pwdata;
            r_hready  <= w_hready;
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed cycle checks plus a randomized AHB master,
// with a scoreboard comparing every completed APB access against the accepted transfers.
module tb_apb_fsm_controller;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        valid = 1'b0;
    logic        HWRITE = 1'b0;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [2:0]  TEMP_SEL = '0;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        HREADYout;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [2:0]  s;
        logic [31:0] d;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .valid(valid), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .TEMP_SEL(TEMP_SEL),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .HREADYout(HREADYout)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [2:0] sel_exp(input logic [31:0] a, input logic [2:0] s);
        return (a[15:12] <= 4'd2) ? s : 3'b000;
    endfunction

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d);
        xfer_t x;
        x.a = a; x.w = w; x.s = sel_exp(a, s); x.d = d;
        return x;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_ph(input logic v, input logic [31:0] a, input logic w, input logic [2:0] s);
        valid = v; HADDR = a; HWRITE = w; TEMP_SEL = s;
    endtask

    task automatic chk(input string nm, input logic [2:0] ps, input logic pe, input logic hr);
        checks++;
        if ({PSEL, PENABLE, HREADYout} !== {ps, pe, hr}) begin
            errors++;
            $display("FAIL %s: got psel=%b penable=%b hready=%b, want psel=%b penable=%b hready=%b",
                     nm, PSEL, PENABLE, HREADYout, ps, pe, hr);
        end
    endtask

    task automatic chk_addr(input string nm, input logic [31:0] a);
        checks++;
        if (PADDR !== a) begin
            errors++;
            $display("FAIL %s: got paddr=%h, want %h", nm, PADDR, a);
        end
    endtask

    task automatic chk_rst(input string nm);
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout} !== {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL %s: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h hready=%b, want all zero, hready=1",
                     nm, PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout);
        end
    endtask

    // Monitor: every enable cycle completes one APB access, which must match the
    // oldest accepted transfer and repeat exactly what the preceding setup cycle showed.
    logic [2:0]  prev_psel;
    logic        prev_pen, prev_pwrite;
    logic [31:0] prev_paddr, prev_pwdata;

    always @(negedge HCLK) begin
        if (HRESETn && PENABLE) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL apb_xfer: access paddr=%h with no accepted transfer outstanding", PADDR);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                if (PADDR !== e.a || PSEL !== e.s || PWRITE !== e.w || (e.w && PWDATA !== e.d)) begin
                    errors++;
                    $display("FAIL apb_xfer: got a=%h sel=%b w=%b d=%h, want a=%h sel=%b w=%b d=%h",
                             PADDR, PSEL, PWRITE, PWDATA, e.a, e.s, e.w, e.d);
                end
            end
            checks++;
            if (prev_pen !== 1'b0 || prev_psel !== PSEL || prev_paddr !== PADDR ||
                prev_pwrite !== PWRITE || prev_pwdata !== PWDATA) begin
                errors++;
                $display("FAIL apb_stable: setup pen=%b sel=%b a=%h w=%b d=%h, enable sel=%b a=%h w=%b d=%h",
                         prev_pen, prev_psel, prev_paddr, prev_pwrite, prev_pwdata,
                         PSEL, PADDR, PWRITE, PWDATA);
            end
        end
        prev_psel = PSEL; prev_pen = PENABLE; prev_pwrite = PWRITE;
        prev_paddr = PADDR; prev_pwdata = PWDATA;
    end

    initial begin
        logic        v, w, rdy, dp_w, have;
        logic [31:0] a, d, dp_d;
        logic [2:0]  s;
        logic [3:0]  nib;
        int          n, guard;

        #2 HRESETn = 1'b0;
        #1 chk_rst("reset_init");
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        chk("idle_after_reset", 3'b000, 1'b0, 1'b1);

        // Single read
        addr_ph(1'b1, 32'h4000_1004, 1'b0, 3'b010);
        exp_q.push_back(mk(32'h4000_1004, 1'b0, 3'b010, 32'h0));
        tick();
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        chk("read_setup", 3'b010, 1'b0, 1'b0);
        chk_addr("read_setup_addr", 32'h4000_1004);
        tick(); chk("read_enable", 3'b010, 1'b1, 1'b1);
        tick(); chk("read_idle", 3'b000, 1'b0, 1'b1);

        // Single write
        addr_ph(1'b1, 32'h4000_0008, 1'b1, 3'b001);
        exp_q.push_back(mk(32'h4000_0008, 1'b1, 3'b001, 32'hDEAD_BEEF));
        tick();
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        HWDATA = 32'hDEAD_BEEF;
        chk("write_wwait", 3'b000, 1'b0, 1'b1);
        tick(); chk("write_setup", 3'b001, 1'b0, 1'b0);
        HWDATA = 32'h0BAD_0BAD;
        tick(); chk("write_enable", 3'b001, 1'b1, 1'b1);
        tick(); chk("write_idle", 3'b000, 1'b0, 1'b1);

        // Write then back-to-back read accepted in WWAIT
        addr_ph(1'b1, 32'h4000_2000, 1'b1, 3'b100);
        exp_q.push_back(mk(32'h4000_2000, 1'b1, 3'b100, 32'hA5A5_0001));
        tick();
        HWDATA = 32'hA5A5_0001;
        addr_ph(1'b1, 32'h4000_0010, 1'b0, 3'b001);
        exp_q.push_back(mk(32'h4000_0010, 1'b0, 3'b001, 32'h0));
        chk("wr_rd_wwait", 3'b000, 1'b0, 1'b1);
        tick();
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        chk("wr_rd_writep", 3'b100, 1'b0, 1'b0);
        tick(); chk("wr_rd_wenablep", 3'b100, 1'b1, 1'b0);
        tick(); chk("wr_rd_read", 3'b001, 1'b0, 1'b0);
        chk_addr("wr_rd_read_addr", 32'h4000_0010);
        tick(); chk("wr_rd_renable", 3'b001, 1'b1, 1'b1);
        tick(); chk("wr_rd_idle", 3'b000, 1'b0, 1'b1);

        // Write then write: second data held during the stall
        addr_ph(1'b1, 32'h4000_1000, 1'b1, 3'b010);
        exp_q.push_back(mk(32'h4000_1000, 1'b1, 3'b010, 32'hCAFE_0001));
        tick();
        HWDATA = 32'hCAFE_0001;
        addr_ph(1'b1, 32'h4000_0020, 1'b1, 3'b001);
        exp_q.push_back(mk(32'h4000_0020, 1'b1, 3'b001, 32'h1234_5678));
        tick();
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        HWDATA = 32'h1234_5678;
        chk("wr_wr_writep", 3'b010, 1'b0, 1'b0);
        tick(); chk("wr_wr_wenablep", 3'b010, 1'b1, 1'b0);
        tick(); chk("wr_wr_write", 3'b001, 1'b0, 1'b0);
        tick(); chk("wr_wr_wenable", 3'b001, 1'b1, 1'b1);
        tick(); chk("wr_wr_idle", 3'b000, 1'b0, 1'b1);

        // Unmapped window still runs a full access, with no select
        addr_ph(1'b1, 32'h4000_3000, 1'b0, 3'b100);
        exp_q.push_back(mk(32'h4000_3000, 1'b0, 3'b100, 32'h0));
        tick();
        addr_ph(1'b0, 32'h5000_0000, 1'b0, 3'b000);
        chk("unmapped_setup", 3'b000, 1'b0, 1'b0);
        tick(); chk("unmapped_enable", 3'b000, 1'b1, 1'b1);
        tick(); chk("oor_idle", 3'b000, 1'b0, 1'b1);
        tick(); chk("oor_idle2", 3'b000, 1'b0, 1'b1);

        // Reset in the middle of a write enable phase
        addr_ph(1'b1, 32'h4000_0004, 1'b1, 3'b001);
        exp_q.push_back(mk(32'h4000_0004, 1'b1, 3'b001, 32'h7777_8888));
        tick();
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        HWDATA = 32'h7777_8888;
        tick(); tick();
        chk("pre_reset_wenable", 3'b001, 1'b1, 1'b1);
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1 chk_rst("reset_mid_wenable");
        #1 HRESETn = 1'b1;
        exp_q.delete();
        tick(); chk("idle_after_mid_reset", 3'b000, 1'b0, 1'b1);

        // Randomized pipelined AHB master
        dp_w = 1'b0; dp_d = '0; have = 1'b0;
        v = 1'b0; w = 1'b0; a = '0; s = '0; d = '0;
        n = 0;
        while (n < 400) begin
            if (!have) begin
                nib = 4'($urandom_range(0, 4));
                v = ($urandom_range(0, 3) != 0);
                w = 1'($urandom);
                a = {16'h4000, nib, 12'($urandom)};
                s = (nib <= 4'd2) ? (3'b001 << nib) : 3'($urandom);
                d = $urandom;
                have = 1'b1;
            end
            addr_ph(v, a, w, s);
            HWDATA = dp_w ? dp_d : $urandom;
            rdy = HREADYout;
            tick();
            if (rdy) begin
                if (v)
                    exp_q.push_back(mk(a, w, s, d));
                dp_w = v & w;
                dp_d = d;
                have = 1'b0;
                n++;
            end
        end
        addr_ph(1'b0, 32'h0, 1'b0, 3'b000);
        HWDATA = dp_d;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d accepted transfers never reached APB, want 0", exp_q.size());
        end
        tick(); chk("final_idle", 3'b000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
